// File: rtl/chip_pkg.sv
// Shared types for the bank access sequencer.
//   cmd_op_e    : command opcode carried on cmd_op (ACT/RD/WR/PRE)
//   seq_state_e : sequencer state (IDLE, RD_BURST, WR_BURST)
package chip_pkg;

  typedef enum logic [1:0] {
    ACT = 2'b00,
    RD  = 2'b01,
    WR  = 2'b10,
    PRE = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_BURST = 2'b01,
    WR_BURST = 2'b10
  } seq_state_e;

endpackage

// File: rtl/bank_access_sequencer_if.sv
// Host-side bus of the bank access sequencer.
//   cmd_*       : command handshake (valid/ready) with op, bank group, bank, row, column
//   wdata*      : write-data handshake, consumed one beat per accepted word during a write burst
//   rdata*, err : registered read data with valid/last flags, and a one-cycle error pulse
// master = command source, slave = sequencer.
interface bank_access_sequencer_if
  import chip_pkg::*;
#(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int DEVICE_WIDTH = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  cmd_op_e                 cmd_op;
  logic [BGWIDTH-1:0]      cmd_bg;
  logic [BAWIDTH-1:0]      cmd_ba;
  logic [CHWIDTH-1:0]      cmd_row;
  logic [COLWIDTH-1:0]     cmd_col;
  logic [DEVICE_WIDTH-1:0] wdata;
  logic                    wdata_valid;
  logic                    wdata_ready;
  logic [DEVICE_WIDTH-1:0] rdata;
  logic                    rdata_valid;
  logic                    rdata_last;
  logic                    err;

  modport master (
    output cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col, wdata, wdata_valid,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, rdata_last, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col, wdata, wdata_valid,
    output cmd_ready, wdata_ready, rdata, rdata_valid, rdata_last, err
  );
endinterface

// File: rtl/bank_state_table.sv
// Per-bank row register and open flag.
//   clk, rst          : clock, synchronous active-high reset (clears rows and flags)
//   we, wr_bg, wr_ba  : single write port selecting one bank
//   wr_open           : new open flag for the selected bank
//   wr_row_en, wr_row : optionally load the row register (ACT loads, PRE keeps it)
//   row_o, open_o     : full-array outputs
module bank_state_table #(
  parameter int BGWIDTH    = 2,
  parameter int BANKGROUPS = 2**BGWIDTH,
  parameter int BAWIDTH    = 2,
  parameter int CHWIDTH    = 5
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                we,
  input  logic [BGWIDTH-1:0]                                  wr_bg,
  input  logic [BAWIDTH-1:0]                                  wr_ba,
  input  logic                                                wr_open,
  input  logic                                                wr_row_en,
  input  logic [CHWIDTH-1:0]                                  wr_row,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]  row_o,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0]               open_o
);
  localparam int BPG = 2**BAWIDTH;

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BPG; b++) begin : g_bank
      logic sel;
      assign sel = we && (wr_bg == BGWIDTH'(g)) && (wr_ba == BAWIDTH'(b));

      always_ff @(posedge clk) begin
        if (rst) begin
          row_o[g][b]  <= '0;
          open_o[g][b] <= 1'b0;
        end else if (sel) begin
          open_o[g][b] <= wr_open;
          if (wr_row_en) row_o[g][b] <= wr_row;
        end
      end
    end
  end
endmodule

// File: rtl/bank_access_sequencer.sv
// Bank access sequencer: takes ACT/RD/WR/PRE commands and turns RD/WR into
// BL-beat bursts on the chip-side per-bank ports.
//   clk, rst : clock, synchronous active-high reset
//   bus      : host command / write-data / read-data interface (slave side)
//   rd_o_wr  : per-bank write strobe, high only on an accepted write beat
//   dqin     : write data fanned out to all banks (zero outside write bursts)
//   dqout    : per-bank read data, sampled from the addressed bank
//   row      : per-bank open row register
//   column   : current beat column, fanned out to all banks
// Build option: define BANK_ACCESS_CHECK_EN to drop RD/WR to a closed bank and
// ACT to an open bank, pulsing err the following cycle.
module bank_access_sequencer
  import chip_pkg::*;
#(
  parameter int BGWIDTH      = 2,
  parameter int BANKGROUPS   = 2**BGWIDTH,
  parameter int BAWIDTH      = 2,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int CHWIDTH      = 5,
  parameter int BL           = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  bank_access_sequencer_if.slave                                  bus,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0]                   rd_o_wr,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0] dqin,
  input  logic [BANKGROUPS-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0] dqout,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0][CHWIDTH-1:0]      row,
  output logic [BANKGROUPS-1:0][2**BAWIDTH-1:0][COLWIDTH-1:0]     column
);
  localparam int                  BPG       = 2**BAWIDTH;
  localparam int                  BLW       = $clog2(BL);
  localparam logic [COLWIDTH-1:0] BL_MASK   = COLWIDTH'(BL-1);
  localparam logic [BLW-1:0]      LAST_BEAT = BLW'(BL-1);

  seq_state_e           state_q, state_d;
  cmd_op_e              op;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [COLWIDTH-1:0]  col_q, beat_col;
  logic [BLW-1:0]       beat_q, beat_d;
  logic                 acc, drop, latch, beat_en, rd_beat, wr_beat;
  logic                 tbl_we, tbl_open, tbl_row_en;
  logic [BANKGROUPS-1:0][BPG-1:0] open_tbl;

  logic [DEVICE_WIDTH-1:0] rdata_q;
  logic                    rdata_valid_q, rdata_last_q;

  assign op = bus.cmd_op;

  // Commands are only taken in IDLE and never while reset is held.
  assign bus.cmd_ready   = (state_q == IDLE) && !rst;
  assign bus.wdata_ready = (state_q == WR_BURST) && !rst;
  assign acc             = bus.cmd_valid && bus.cmd_ready;

`ifdef BANK_ACCESS_CHECK_EN
  logic sel_open, err_q;
  assign sel_open = open_tbl[bus.cmd_bg][bus.cmd_ba];
  assign drop     = (op == ACT) ? sel_open :
                    ((op == RD) || (op == WR)) ? !sel_open : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= acc && drop;
  end
  assign bus.err = err_q;
`else
  // Open flags are still tracked so the table is identical in both builds.
  logic unused_open;
  assign unused_open = ^open_tbl;
  assign drop        = 1'b0;
  assign bus.err     = 1'b0;
`endif

  bank_state_table #(
    .BGWIDTH   (BGWIDTH),
    .BANKGROUPS(BANKGROUPS),
    .BAWIDTH   (BAWIDTH),
    .CHWIDTH   (CHWIDTH)
  ) u_tbl (
    .clk      (clk),
    .rst      (rst),
    .we       (tbl_we),
    .wr_bg    (bus.cmd_bg),
    .wr_ba    (bus.cmd_ba),
    .wr_open  (tbl_open),
    .wr_row_en(tbl_row_en),
    .wr_row   (bus.cmd_row),
    .row_o    (row),
    .open_o   (open_tbl)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    latch      = 1'b0;
    beat_en    = 1'b0;
    tbl_we     = 1'b0;
    tbl_open   = 1'b0;
    tbl_row_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && !drop) begin
          unique case (op)
            ACT: begin tbl_we = 1'b1; tbl_open = 1'b1; tbl_row_en = 1'b1; end
            PRE: tbl_we = 1'b1;
            RD:  begin latch = 1'b1; beat_d = '0; state_d = RD_BURST; end
            WR:  begin latch = 1'b1; beat_d = '0; state_d = WR_BURST; end
          endcase
        end
      end
      RD_BURST: beat_en = !rst;
      WR_BURST: beat_en = !rst && bus.wdata_valid;
      default:  state_d = IDLE;
    endcase
    if (beat_en) begin
      if (beat_q == LAST_BEAT) begin
        beat_d  = '0;
        state_d = IDLE;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  assign rd_beat = beat_en && (state_q == RD_BURST);
  assign wr_beat = beat_en && (state_q == WR_BURST);

  // Beat column wraps inside the BL-aligned block: upper bits from the command
  // column, low bits advance modulo BL.
  assign beat_col = (col_q & ~BL_MASK) | ((col_q + COLWIDTH'(beat_q)) & BL_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      bg_q          <= '0;
      ba_q          <= '0;
      col_q         <= '0;
      beat_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
    end else begin
      beat_q        <= beat_d;
      rdata_valid_q <= rd_beat;
      rdata_last_q  <= rd_beat && (beat_q == LAST_BEAT);
      if (rd_beat) rdata_q <= dqout[bg_q][ba_q];
      if (latch) begin
        bg_q  <= bus.cmd_bg;
        ba_q  <= bus.cmd_ba;
        col_q <= bus.cmd_col;
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.rdata_last  = rdata_last_q;

  always_comb begin
    rd_o_wr = '0;
    dqin    = '0;
    column  = '0;
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BPG; b++) begin
        column[g][b]  = beat_col;
        dqin[g][b]    = (state_q == WR_BURST) ? bus.wdata : '0;
        rd_o_wr[g][b] = wr_beat && (bg_q == BGWIDTH'(g)) && (ba_q == BAWIDTH'(b));
      end
    end
  end
endmodule

// File: doc/bank_access_sequencer.md
BANK_ACCESS_SEQUENCER -- requirements
Module: bank_access_sequencer

Interface
REQ-001 SHALL have parameter BGWIDTH, default 2, meaning bank-group index width.
REQ-002 SHALL have parameter BANKGROUPS, default 2**BGWIDTH, meaning number of bank groups (1 for DDR3 and earlier).
REQ-003 SHALL have parameter BAWIDTH, default 2, meaning bank-index width (BANKSPERGROUP = 2**BAWIDTH).
REQ-004 SHALL have parameter COLWIDTH, default 10, meaning column width.
REQ-005 SHALL have parameter DEVICE_WIDTH, default 4, meaning data bits per beat.
REQ-006 SHALL have parameter CHWIDTH, default 5, meaning row width.
REQ-007 SHALL have parameter BL, default 8, meaning burst length (power of two, at most 2**COLWIDTH).
REQ-008 SHALL have one clock; reset is synchronous and active-high: clk input 1 (clock), rst input 1 (reset).
REQ-009 Command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (00 ACT, 01 RD, 10 WR, 11 PRE); cmd_bg in BGWIDTH; cmd_ba in BAWIDTH; cmd_row in CHWIDTH; cmd_col in COLWIDTH.
REQ-010 Write-data ports: wdata in DEVICE_WIDTH; wdata_valid in 1; wdata_ready out 1.
REQ-011 Read-data and status ports: rdata out DEVICE_WIDTH; rdata_valid out 1; rdata_last out 1; err out 1 (one-cycle pulse).
REQ-012 Chip-side ports, each [BANKGROUPS-1:0][BANKSPERGROUP-1:0]: rd_o_wr out 1; dqin out DEVICE_WIDTH; dqout in DEVICE_WIDTH; row out CHWIDTH; column out COLWIDTH.

Function
REQ-013 SHALL implement states IDLE, RD_BURST, WR_BURST; cmd_ready = 1 only in IDLE.
REQ-014 SHALL complete ACT in the acceptance cycle: store cmd_row in that bank's row register, set its open flag, stay in IDLE.
REQ-015 SHALL complete PRE in the acceptance cycle: clear that bank's open flag, retain its row register, stay in IDLE.
REQ-016 SHALL register bg/ba/col on RD/WR acceptance and enter RD_BURST/WR_BURST next cycle.
REQ-017 SHALL drive row[g][b] continuously from each bank's row register.
REQ-018 SHALL drive column to the current beat column for all banks, and dqin to wdata for all banks.
REQ-019 SHALL compute beat-k column as {col[COLWIDTH-1:log2 BL], (col[log2 BL-1:0]+k) mod BL} (wrap within the BL-aligned block).
REQ-020 RD_BURST: SHALL issue one beat per cycle with no stall; rd_o_wr stays 0 everywhere.
REQ-021 RD_BURST: rdata SHALL be dqout[bg][ba] registered; rdata_valid SHALL be high exactly one cycle after each beat; rdata_last SHALL accompany the BL-th datum.
REQ-022 WR_BURST: wdata_ready = 1; a beat SHALL occur only on wdata_valid, with rd_o_wr[bg][ba] = 1 in that cycle; other banks 0.
REQ-023 WR_BURST: with wdata_valid low, SHALL hold the beat counter and drive rd_o_wr = 0.
REQ-024 SHALL return to IDLE in the cycle after the final beat; a new command MAY be accepted that cycle.
REQ-025 Outside WR_BURST, wdata_ready SHALL be 0 and wdata SHALL be ignored.

Reset
REQ-026 On rst: state IDLE; all open flags and row registers 0; beat counter 0.
REQ-027 On rst: cmd_ready 1 in the cycle after rst deasserts; rdata_valid, rdata_last, err, wdata_ready, all rd_o_wr 0; rdata, column, dqin 0.
REQ-028 rst mid-burst SHALL abort the burst with no further beats, no rdata_valid, and no rd_o_wr.

Configuration
REQ-029 Macro BANK_ACCESS_CHECK_EN defined: RD/WR to a closed bank, or ACT to an open bank, SHALL be accepted and dropped, with err pulsed the next cycle and no state change.
REQ-030 Macro BANK_ACCESS_CHECK_EN undefined: all commands SHALL execute regardless of open flags, and err SHALL be tied 0.

Structure
REQ-031 Shared package chip_pkg SHALL hold the cmd_op enum (ACT/RD/WR/PRE) and the sequencer state enum.
REQ-032 Sub-module bank_state_table SHALL hold the per-bank row registers and open flags, with one write port and full-array row/open outputs.

Verification
REQ-033 ACT bg1 ba2 row 0x15, then RD col 0x005 -> columns 5,6,7,0,1,2,3,4 on consecutive cycles; 8 rdata_valid one cycle later; last datum has rdata_last.
REQ-034 ACT bg0 ba0 row 3; WR col 0x010 with wdata_valid low in beats 3-4 -> rd_o_wr[0][0] high only on valid cycles; 8 writes to cols 0x10-0x17; a following RD reads them back.
REQ-035 With BANK_ACCESS_CHECK_EN, RD to never-activated bg2 ba1 -> err pulse, no rdata_valid, cmd_ready stays 1; without the macro, the burst runs and err stays 0.
REQ-036 ACT, PRE, RD to the same bank with the check enabled -> err; then ACT row 7 and RD -> row[bg][ba] = 7 and the burst executes.
REQ-037 rst asserted at RD beat 4 -> no rdata_valid after rst; IDLE with cmd_ready 1 next cycle; row outputs 0.
